// File: rtl/watch_pkg.sv
// watch_pkg
//   Shared types and constants for the watch time-of-day logic.
//   - TIME_FIELD_W : width of each HH/MM/SS field
//   - SEC_MAX/MIN_MAX : last value of the seconds/minutes fields
//   - time_field_t : one unsigned time field
//   - hms_t        : packed hours/minutes/seconds triple
//   - wrap_inc/wrap_dec : modular +1/-1 on a field with a given maximum
package watch_pkg;

  localparam int TIME_FIELD_W = 6;

  typedef logic [TIME_FIELD_W-1:0] time_field_t;

  localparam time_field_t SEC_MAX = time_field_t'(59);
  localparam time_field_t MIN_MAX = time_field_t'(59);

  typedef struct packed {
    time_field_t hours;
    time_field_t minutes;
    time_field_t seconds;
  } hms_t;

  function automatic time_field_t wrap_inc(input time_field_t v, input time_field_t max_v);
    return (v == max_v) ? '0 : v + time_field_t'(1);
  endfunction

  function automatic time_field_t wrap_dec(input time_field_t v, input time_field_t max_v);
    return (v == '0) ? max_v : v - time_field_t'(1);
  endfunction

endpackage

// File: rtl/watch_tick_prescaler.sv
// watch_tick_prescaler
//   Divides the system clock down to a once-per-second tick.
//   Counter runs 0..CLK_HZ-1 while run=1 and is held at 0 while run=0,
//   so any partial second is discarded when counting stops.
// Ports
//   clk   in  system clock
//   reset in  synchronous, active-high
//   run   in  1 = count, 0 = clear and hold
//   tick  out combinational, high during the terminal-count cycle
module watch_tick_prescaler
  import watch_pkg::*;
#(
  parameter int CLK_HZ  = 32768,
  parameter int PRESC_W = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam logic [PRESC_W-1:0] TERM_CNT = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_term;

  assign w_term = (r_cnt == TERM_CNT);
  assign tick   = run & w_term;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      r_cnt <= '0;
    end else if (w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/watch_timekeeper.sv
// watch_timekeeper
//   HH:MM:SS time-of-day counter with its own 1 Hz prescaler and
//   set-mode minute/hour adjustment.
//   Optional feature macro: WATCH_ALARM_EN (adds alarm compare and ports).
// Ports
//   clk, reset                      system clock, synchronous active-high reset
//   set_mode                        1 = halt counting, accept inc/dec pulses
//   min_inc/min_dec/hour_inc/hour_dec  single-cycle adjust pulses
//   seconds/minutes/hours           registered time fields
//   tick_1hz                        pulse coincident with each run-mode second advance
//   day_rollover                    pulse coincident with the wrap to 00:00:00
//   [WATCH_ALARM_EN] alarm_hours, alarm_minutes, alarm_arm in; alarm_fire out
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int CLK_HZ        = 32768,
  parameter int HOURS_PER_DAY = 24,
  parameter int PRESC_W       = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_mode,
  input  logic       min_inc,
  input  logic       min_dec,
  input  logic       hour_inc,
  input  logic       hour_dec,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [5:0] hours,
  output logic       tick_1hz,
  output logic       day_rollover
`ifdef WATCH_ALARM_EN
  ,
  input  logic [5:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_arm,
  output logic       alarm_fire
`endif
);

  localparam time_field_t HOUR_MAX = time_field_t'(HOURS_PER_DAY - 1);

  hms_t r_time;
  hms_t w_next;
  logic w_tick;
  logic w_roll;
  logic r_tick;
  logic r_roll;

  watch_tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .run  (~set_mode),
    .tick (w_tick)
  );

  // w_tick is already gated by run, so the carry chain only moves in run mode.
  always_comb begin
    w_next = r_time;
    w_roll = 1'b0;
    if (set_mode) begin
      w_next.seconds = '0;
      if (min_inc && !min_dec) begin
        w_next.minutes = wrap_inc(r_time.minutes, MIN_MAX);
      end else if (min_dec && !min_inc) begin
        w_next.minutes = wrap_dec(r_time.minutes, MIN_MAX);
      end
      if (hour_inc && !hour_dec) begin
        w_next.hours = wrap_inc(r_time.hours, HOUR_MAX);
      end else if (hour_dec && !hour_inc) begin
        w_next.hours = wrap_dec(r_time.hours, HOUR_MAX);
      end
    end else if (w_tick) begin
      w_next.seconds = wrap_inc(r_time.seconds, SEC_MAX);
      if (r_time.seconds == SEC_MAX) begin
        w_next.minutes = wrap_inc(r_time.minutes, MIN_MAX);
        if (r_time.minutes == MIN_MAX) begin
          w_next.hours = wrap_inc(r_time.hours, HOUR_MAX);
          w_roll       = (r_time.hours == HOUR_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_time <= '0;
      r_tick <= 1'b0;
      r_roll <= 1'b0;
    end else begin
      r_time <= w_next;
      r_tick <= w_tick;
      r_roll <= w_roll;
    end
  end

  assign seconds      = r_time.seconds;
  assign minutes      = r_time.minutes;
  assign hours        = r_time.hours;
  assign tick_1hz     = r_tick;
  assign day_rollover = r_roll;

`ifdef WATCH_ALARM_EN
  // Compare against the value about to be registered so the pulse lines up
  // with the displayed match. Only tick-driven advances can fire.
  logic w_fire;
  logic r_fire;

  assign w_fire = alarm_arm & ~set_mode & w_tick &
                  (w_next.seconds == '0) &
                  (w_next.minutes == alarm_minutes) &
                  (w_next.hours == alarm_hours);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fire <= 1'b0;
    end else begin
      r_fire <= w_fire;
    end
  end

  assign alarm_fire = r_fire;
`endif

endmodule

// File: tb/tb_watch_timekeeper.sv
module tb_watch_timekeeper;
  import watch_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       set_mode;
  logic       min_inc, min_dec, hour_inc, hour_dec;
  logic [5:0] seconds, minutes, hours;
  logic       tick_1hz, day_rollover;
  logic [5:0] seconds12, minutes12, hours12;
  logic       tick12, roll12;
`ifdef WATCH_ALARM_EN
  logic [5:0] alarm_hours, alarm_minutes;
  logic       alarm_arm;
  logic       alarm_fire, alarm_fire12;
  int         fire_cnt = 0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  watch_timekeeper #(.CLK_HZ(4), .HOURS_PER_DAY(24), .PRESC_W(2)) dut (
    .clk(clk), .reset(reset), .set_mode(set_mode),
    .min_inc(min_inc), .min_dec(min_dec), .hour_inc(hour_inc), .hour_dec(hour_dec),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .tick_1hz(tick_1hz), .day_rollover(day_rollover)
`ifdef WATCH_ALARM_EN
    , .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .alarm_arm(alarm_arm), .alarm_fire(alarm_fire)
`endif
  );

  watch_timekeeper #(.CLK_HZ(4), .HOURS_PER_DAY(12), .PRESC_W(2)) dut12 (
    .clk(clk), .reset(reset), .set_mode(set_mode),
    .min_inc(min_inc), .min_dec(min_dec), .hour_inc(hour_inc), .hour_dec(hour_dec),
    .seconds(seconds12), .minutes(minutes12), .hours(hours12),
    .tick_1hz(tick12), .day_rollover(roll12)
`ifdef WATCH_ALARM_EN
    , .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .alarm_arm(alarm_arm), .alarm_fire(alarm_fire12)
`endif
  );

`ifdef WATCH_ALARM_EN
  always @(negedge clk) if (alarm_fire === 1'b1) fire_cnt++;
`endif

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_h"}, 32'(hours), 32'(h));
    chk({tag, "_m"}, 32'(minutes), 32'(m));
    chk({tag, "_s"}, 32'(seconds), 32'(s));
  endtask

  // which: 0 min_inc, 1 min_dec, 2 hour_inc, 3 hour_dec
  task automatic pulse(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        0: min_inc  = 1'b1;
        1: min_dec  = 1'b1;
        2: hour_inc = 1'b1;
        default: hour_dec = 1'b1;
      endcase
      step(1);
      min_inc = 1'b0; min_dec = 1'b0; hour_inc = 1'b0; hour_dec = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; set_mode = 1'b0;
    min_inc = 1'b0; min_dec = 1'b0; hour_inc = 1'b0; hour_dec = 1'b0;
`ifdef WATCH_ALARM_EN
    alarm_hours = 6'd7; alarm_minutes = 6'd30; alarm_arm = 1'b0;
`endif
    step(2);
    chk_time("rst", 0, 0, 0);
    chk("rst_tick", 32'(tick_1hz), 0);
    chk("rst_roll", 32'(day_rollover), 0);
    reset = 1'b0;

    // 1. reach 10:20:30 then reset mid-count
    set_mode = 1'b1;
    pulse(2, 10);
    pulse(0, 20);
    chk_time("set_1020", 10, 20, 0);
    set_mode = 1'b0;
    step(120);
    chk_time("run_102030", 10, 20, 30);
    step(2);
    reset = 1'b1;
    step(1);
    chk_time("rst_mid", 0, 0, 0);
    chk("rst_mid_tick", 32'(tick_1hz), 0);
    reset = 1'b0;
    step(3);
    chk("post_rst_s3", 32'(seconds), 0);
    chk("post_rst_t3", 32'(tick_1hz), 0);
    step(1);
    chk("post_rst_s4", 32'(seconds), 1);
    chk("post_rst_t4", 32'(tick_1hz), 1);

    // 2. set 23:59:00 (and 11:59:00 on the 12h copy), run to rollover
    set_mode = 1'b1;
    step(1);
    chk("set_sec0", 32'(seconds), 0);
    pulse(3, 1);
    chk("hdec_24", 32'(hours), 23);
    chk("hdec_12", 32'(hours12), 11);
    chk("hdec_noroll", 32'(day_rollover), 0);
    pulse(1, 1);
    chk_time("set_2359", 23, 59, 0);
    set_mode = 1'b0;
    step(236);
    chk_time("run_235959", 23, 59, 59);
    step(3);
    chk("pre_roll_tick", 32'(tick_1hz), 0);
    chk("pre_roll_s", 32'(seconds), 59);
    step(1);
    chk_time("roll", 0, 0, 0);
    chk("roll_tick", 32'(tick_1hz), 1);
    chk("roll_pulse", 32'(day_rollover), 1);
    chk("roll12_pulse", 32'(roll12), 1);
    chk("roll12_h", 32'(hours12), 0);
    step(1);
    chk("roll_tick_end", 32'(tick_1hz), 0);
    chk("roll_pulse_end", 32'(day_rollover), 0);

    // 3. min_inc at 05:59 wraps minutes only
    step(2);
    set_mode = 1'b1;
    step(1);
    pulse(2, 5);
    pulse(1, 1);
    chk_time("set_0559", 5, 59, 0);
    pulse(0, 1);
    chk_time("minc_wrap", 5, 0, 0);
    chk("minc_noroll", 32'(day_rollover), 0);

    // 4. simultaneous pulses
    min_inc = 1'b1; min_dec = 1'b1; hour_inc = 1'b1;
    step(1);
    min_inc = 1'b0; min_dec = 1'b0; hour_inc = 1'b0;
    chk_time("sim_min", 6, 0, 0);
    min_inc = 1'b1; hour_inc = 1'b1; hour_dec = 1'b1;
    step(1);
    min_inc = 1'b0; hour_inc = 1'b0; hour_dec = 1'b0;
    chk_time("sim_hour", 6, 1, 0);
    set_mode = 1'b0;
    min_inc = 1'b1; hour_dec = 1'b1;
    step(1);
    min_inc = 1'b0; hour_dec = 1'b0;
    chk_time("run_ignore", 6, 1, 0);

    // 5. resume after set mode, then abandon a partial second
    step(2);
    chk("resume_s3", 32'(seconds), 0);
    chk("resume_t3", 32'(tick_1hz), 0);
    step(1);
    chk("resume_s4", 32'(seconds), 1);
    chk("resume_t4", 32'(tick_1hz), 1);
    step(2);
    set_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("partial_tick", 32'(tick_1hz), 0);
    end
    chk_time("partial", 6, 1, 0);

`ifdef WATCH_ALARM_EN
    // 6. alarm at 07:30
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    set_mode = 1'b1;
    pulse(2, 7);
    pulse(1, 31);
    chk_time("al_set", 7, 29, 0);
    alarm_arm = 1'b1;
    set_mode = 1'b0;
    step(236);
    chk_time("al_pre", 7, 29, 59);
    chk("al_pre_cnt", 32'(fire_cnt), 0);
    step(4);
    chk_time("al_hit", 7, 30, 0);
    chk("al_fire", 32'(alarm_fire), 1);
    step(1);
    chk("al_fire_end", 32'(alarm_fire), 0);
    chk("al_cnt1", 32'(fire_cnt), 1);
    set_mode = 1'b1;
    step(1);
    pulse(1, 1);
    pulse(0, 1);
    step(2);
    chk_time("al_edit", 7, 30, 0);
    chk("al_edit_cnt", 32'(fire_cnt), 1);
    pulse(1, 1);
    alarm_arm = 1'b0;
    set_mode = 1'b0;
    step(244);
    chk_time("al_disarm", 7, 30, 1);
    chk("al_disarm_cnt", 32'(fire_cnt), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
